// File: rtl/path_reorder.sv
// path_reorder
// Captures a goal-first solver path (first beat (13,13), last beat (1,1)),
// validates it while it streams in, then replays it start-first on a
// valid/ready output. A rejected frame produces a single error beat.
//
// Ports
//   clk           : single clock, all state on rising edge
//   rst_n         : synchronous active-low reset
//   in_valid      : upstream path-beat strobe (frame = contiguous burst)
//   in_not_valid  : upstream "maze unsolvable" flag, qualified by in_valid
//   in_x, in_y    : upstream column / row, legal range 1..13
//   out_ready     : downstream accept
//   out_valid     : output beat valid
//   out_x, out_y  : forward-order column / row
//   out_last      : final beat of a frame
//   path_err      : frame rejected, qualified by out_valid
//   path_len      : number of captured coordinates, held until next frame
module path_reorder #(
    parameter int DEPTH = 169
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       in_not_valid,
    input  logic [3:0] in_x,
    input  logic [3:0] in_y,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] out_x,
    output logic [3:0] out_y,
    output logic       out_last,
    output logic       path_err,
    output logic [7:0] path_len
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_PLAY    = 2'd2,
        S_FAIL    = 2'd3
    } state_t;

    localparam logic [7:0] L_DEPTH = 8'(DEPTH);

    logic [3:0] r_mem_x [0:DEPTH-1];
    logic [3:0] r_mem_y [0:DEPTH-1];

    state_t     r_state;
    logic       r_err;
    logic [7:0] r_rd;
    logic [3:0] r_prev_x;
    logic [3:0] r_prev_y;

    logic       w_beat_bad;
    logic       w_full;
    logic       w_end_ok;
    logic       w_wr_en;
    logic [7:0] w_wr_idx;
    logic [7:0] w_rd_next;
    logic [7:0] w_last_idx;

    // Coordinate lies inside the 13x13 maze interior.
    function automatic logic coord_ok(input logic [3:0] c);
        return (c >= 4'd1) && (c <= 4'd13);
    endfunction

    // Unsigned distance between two 4-bit coordinates (no wrap).
    function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Exactly one axis moves by exactly one.
    function automatic logic step_ok(input logic [3:0] ax, input logic [3:0] ay,
                                     input logic [3:0] bx, input logic [3:0] by);
        logic [3:0] dx;
        logic [3:0] dy;
        dx = abs_diff(ax, bx);
        dy = abs_diff(ay, by);
        return ((dx == 4'd1) && (dy == 4'd0)) || ((dx == 4'd0) && (dy == 4'd1));
    endfunction

    // Per-beat validation and index arithmetic.
    always_comb begin
        w_beat_bad = 1'b0;
        w_full     = (path_len == L_DEPTH);
        w_end_ok   = (r_prev_x == 4'd1) && (r_prev_y == 4'd1);
        w_rd_next  = r_rd - 8'd1;
        w_last_idx = path_len - 8'd1;
        w_wr_en    = 1'b0;
        w_wr_idx   = 8'd0;
        if (r_state == S_IDLE) begin
            // First beat must be the goal; its range is implied by that.
            w_beat_bad = !((in_x == 4'd13) && (in_y == 4'd13));
            w_wr_en    = rst_n && in_valid && !in_not_valid;
            w_wr_idx   = 8'd0;
        end else if (r_state == S_CAPTURE) begin
            w_beat_bad = in_not_valid || w_full || !coord_ok(in_x) || !coord_ok(in_y)
                         || !step_ok(r_prev_x, r_prev_y, in_x, in_y);
            w_wr_en    = rst_n && in_valid && !w_full;
            w_wr_idx   = path_len;
        end else begin
            w_beat_bad = 1'b0;
            w_wr_en    = 1'b0;
            w_wr_idx   = 8'd0;
        end
    end

    // Path storage; contents are don't-care after reset so it carries none.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_x[w_wr_idx] <= in_x;
            r_mem_y[w_wr_idx] <= in_y;
        end
    end

    // Frame FSM with registered output beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_err     <= 1'b0;
            r_rd      <= 8'd0;
            r_prev_x  <= 4'd0;
            r_prev_y  <= 4'd0;
            out_valid <= 1'b0;
            out_x     <= 4'd0;
            out_y     <= 4'd0;
            out_last  <= 1'b0;
            path_err  <= 1'b0;
            path_len  <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (in_not_valid) begin
                            r_state   <= S_FAIL;
                            path_len  <= 8'd0;
                            out_valid <= 1'b1;
                            path_err  <= 1'b1;
                            out_last  <= 1'b1;
                            out_x     <= 4'd0;
                            out_y     <= 4'd0;
                        end else begin
                            r_state  <= S_CAPTURE;
                            path_len <= 8'd1;
                            r_err    <= w_beat_bad;
                            r_prev_x <= in_x;
                            r_prev_y <= in_y;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (in_valid) begin
                        if (w_beat_bad) begin
                            r_err <= 1'b1;
                        end
                        // A beat beyond capacity is dropped; length saturates.
                        if (!w_full) begin
                            path_len <= path_len + 8'd1;
                            r_prev_x <= in_x;
                            r_prev_y <= in_y;
                        end
                    end else if (r_err || !w_end_ok) begin
                        r_state   <= S_FAIL;
                        out_valid <= 1'b1;
                        path_err  <= 1'b1;
                        out_last  <= 1'b1;
                        out_x     <= 4'd0;
                        out_y     <= 4'd0;
                    end else begin
                        // Replay starts from the newest entry, which is the maze start.
                        r_state   <= S_PLAY;
                        r_rd      <= w_last_idx;
                        out_valid <= 1'b1;
                        path_err  <= 1'b0;
                        out_x     <= r_mem_x[w_last_idx];
                        out_y     <= r_mem_y[w_last_idx];
                        out_last  <= (w_last_idx == 8'd0);
                    end
                end
                S_PLAY: begin
                    if (out_ready) begin
                        if (out_last) begin
                            r_state   <= S_IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_x     <= 4'd0;
                            out_y     <= 4'd0;
                        end else begin
                            r_rd     <= w_rd_next;
                            out_x    <= r_mem_x[w_rd_next];
                            out_y    <= r_mem_y[w_rd_next];
                            out_last <= (w_rd_next == 8'd0);
                        end
                    end
                end
                S_FAIL: begin
                    if (out_ready) begin
                        r_state   <= S_IDLE;
                        r_err     <= 1'b0;
                        out_valid <= 1'b0;
                        path_err  <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_path_reorder.sv
module tb_path_reorder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_not_valid;
    logic [3:0] in_x;
    logic [3:0] in_y;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] out_x;
    logic [3:0] out_y;
    logic       out_last;
    logic       path_err;
    logic [7:0] path_len;

    int n_assert = 0;
    int n_fail   = 0;

    // Frame under test and expected output beats.
    int fx[$];
    int fy[$];
    int fnv[$];
    int ex[$];
    int ey[$];
    int el[$];
    int ee[$];
    int exp_len;

    always #5 clk = ~clk;

    path_reorder #(.DEPTH(169)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_not_valid(in_not_valid),
        .in_x        (in_x),
        .in_y        (in_y),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_last    (out_last),
        .path_err    (path_err),
        .path_len    (path_len)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: judge the whole frame from the path rules, then
    // produce either the reversed path or one error beat.
    task automatic build_expect();
        int n;
        int kept;
        bit bad;
        int dx;
        int dy;
        n    = fx.size();
        kept = (n > 169) ? 169 : n;
        bad  = 0;
        ex.delete(); ey.delete(); el.delete(); ee.delete();
        if (fx[0] != 13 || fy[0] != 13) bad = 1;
        if (n > 169) bad = 1;
        for (int i = 0; i < kept; i++) begin
            if (fnv[i] != 0) bad = 1;
            if (fx[i] < 1 || fx[i] > 13 || fy[i] < 1 || fy[i] > 13) bad = 1;
            if (i > 0) begin
                dx = fx[i] - fx[i-1];
                dy = fy[i] - fy[i-1];
                if (dx < 0) dx = -dx;
                if (dy < 0) dy = -dy;
                if (dx + dy != 1) bad = 1;
            end
        end
        if (fx[kept-1] != 1 || fy[kept-1] != 1) bad = 1;
        exp_len = kept;
        if (bad) begin
            ex.push_back(0); ey.push_back(0); el.push_back(1); ee.push_back(1);
        end else begin
            for (int i = kept - 1; i >= 0; i--) begin
                ex.push_back(fx[i]); ey.push_back(fy[i]);
                el.push_back(i == 0 ? 1 : 0); ee.push_back(0);
            end
        end
    endtask

    task automatic clear_frame();
        fx.delete(); fy.delete(); fnv.delete();
    endtask

    task automatic add_beat(input int x, input int y, input int nv);
        fx.push_back(x); fy.push_back(y); fnv.push_back(nv);
    endtask

    task automatic build_lpath();
        clear_frame();
        for (int x = 13; x >= 1; x--) add_beat(x, 13, 0);
        for (int y = 12; y >= 1; y--) add_beat(1, y, 0);
    endtask

    // Boustrophedon walk over the whole maze, n beats long.
    task automatic build_snake(input int n);
        int x;
        int y;
        int dir;
        clear_frame();
        x = 13; y = 13; dir = -1;
        for (int i = 0; i < n; i++) begin
            add_beat(x, y, 0);
            if ((dir < 0 && x == 1) || (dir > 0 && x == 13)) begin
                if (y > 1) begin
                    y = y - 1; dir = -dir;
                end else begin
                    x = x - dir;
                end
            end else begin
                x = x + dir;
            end
        end
    endtask

    // Random monotone path from goal to start, optionally corrupted.
    task automatic build_random();
        int x;
        int y;
        int lefts;
        int ups;
        int kind;
        int idx;
        clear_frame();
        x = 13; y = 13; lefts = 12; ups = 12;
        add_beat(x, y, 0);
        while (lefts + ups > 0) begin
            if (ups == 0 || (lefts > 0 && $urandom_range(0, 1) == 0)) begin
                x--; lefts--;
            end else begin
                y--; ups--;
            end
            add_beat(x, y, 0);
        end
        kind = $urandom_range(0, 6);
        idx  = $urandom_range(1, 24);
        case (kind)
            2: fx[idx] = $urandom_range(0, 15);
            3: fnv[idx] = 1;
            4: void'(fx.pop_back());
            5: fy[0] = 12;
            6: fy[idx] = $urandom_range(0, 15);
            default: ;
        endcase
        if (kind == 4) begin
            void'(fy.pop_back());
            void'(fnv.pop_back());
        end
    endtask

    task automatic send_frame();
        for (int i = 0; i < fx.size(); i++) begin
            @(negedge clk);
            chk("no_output_in_capture", out_valid, 1'b0);
            in_valid     = 1'b1;
            in_not_valid = fnv[i][0];
            in_x         = 4'(fx[i]);
            in_y         = 4'(fy[i]);
        end
        @(negedge clk);
        chk("no_output_in_capture", out_valid, 1'b0);
        in_valid     = 1'b0;
        in_not_valid = 1'b0;
        in_x         = 4'd0;
        in_y         = 4'd0;
    endtask

    // Consume expected beats; mode 0 ready=1, 1 pattern 1,0,0,1, 2 random.
    task automatic drain(input int mode, input int stop);
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        while (idx < stop && cyc < 2000) begin
            @(negedge clk);
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (cyc == 0) chk("first_beat_latency", out_valid, 1'b1);
            if (out_valid) begin
                chk("out_x", out_x, ex[idx]);
                chk("out_y", out_y, ey[idx]);
                chk("out_last", out_last, el[idx]);
                chk("path_err", path_err, ee[idx]);
                if (out_ready) idx++;
            end
            cyc++;
        end
        chk("beat_count", idx, stop);
        if (stop == ex.size()) begin
            @(negedge clk);
            chk("idle_after_frame", out_valid, 1'b0);
            chk("path_len", path_len, exp_len);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_not_valid = 1'b0;
        in_x         = 4'd0;
        in_y         = 4'd0;
        out_ready    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_x", out_x, 4'd0);
        chk("rst_out_y", out_y, 4'd0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_path_err", path_err, 1'b0);
        chk("rst_path_len", path_len, 8'd0);
        rst_n = 1'b1;

        // L-shaped legal path, free-flowing output.
        build_lpath(); build_expect();
        send_frame(); drain(0, ex.size());

        // Unsolvable: one beat with in_not_valid; later in_valid is ignored.
        @(negedge clk);
        in_valid = 1'b1; in_not_valid = 1'b1; in_x = 4'd5; in_y = 4'd5;
        @(negedge clk);
        in_valid = 1'b0; in_not_valid = 1'b0;
        chk("unsolv_valid", out_valid, 1'b1);
        chk("unsolv_err", path_err, 1'b1);
        chk("unsolv_last", out_last, 1'b1);
        chk("unsolv_x", out_x, 4'd0);
        chk("unsolv_y", out_y, 4'd0);
        chk("unsolv_len", path_len, 8'd0);
        in_valid = 1'b1; in_x = 4'd13; in_y = 4'd13;
        @(negedge clk);
        in_valid = 1'b0; in_x = 4'd0; in_y = 4'd0;
        chk("unsolv_stall_valid", out_valid, 1'b1);
        chk("unsolv_stall_len", path_len, 8'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("unsolv_done", out_valid, 1'b0);
        chk("unsolv_ignored_beat", path_len, 8'd0);

        // Adjacency break: second beat jumps two columns.
        build_lpath(); fx[1] = 11; build_expect();
        send_frame(); drain(0, ex.size());

        // Backpressure with ready pattern 1,0,0,1.
        build_lpath(); build_expect();
        send_frame(); drain(1, ex.size());

        // Full-capacity path is legal; one more beat overflows.
        build_snake(169); build_expect();
        send_frame(); drain(2, ex.size());
        build_snake(170); build_expect();
        send_frame(); drain(0, ex.size());

        // Reset during replay after ten beats.
        build_lpath(); build_expect();
        send_frame(); drain(0, 10);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midplay_rst_valid", out_valid, 1'b0);
        chk("midplay_rst_last", out_last, 1'b0);
        chk("midplay_rst_len", path_len, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_rst_quiet", out_valid, 1'b0);
        out_ready = 1'b0;
        build_lpath(); build_expect();
        send_frame(); drain(0, ex.size());

        // Randomized frames against the reference model.
        for (int k = 0; k < 16; k++) begin
            build_random(); build_expect();
            send_frame(); drain($urandom_range(0, 2), ex.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
